// File: rtl/fmv_pixel_output.sv
// FMV pixel output stage: buffers decoder pixels tagged with start-of-line and
// releases one per newpixel strobe, clipping/realigning each scanline.
module fmv_pixel_output #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 24
) (
  input  logic                       clk30,
  input  logic                       reset_n,
  input  logic                       line_start,
  input  logic                       newpixel,
  input  logic [9:0]                 line_pixels,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_sol,
  input  logic                       clear_status,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_active,
  output logic                       underrun,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned CNTW = 10;

  typedef struct packed {
    logic             sol;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ALIGN  = 2'd2
  } state_t;

  entry_t            mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     fill_nxt;
  entry_t            head;
  logic              empty;
  logic              push;
  logic              pop;

  state_t            state;
  state_t            state_nxt;
  logic [CNTW-1:0]   cnt;
  logic [CNTW-1:0]   cnt_nxt;
  logic              emit;
  logic [WIDTH-1:0]  emit_data;
  logic              set_underrun;

  assign head  = mem[rd_ptr];
  assign empty = (fill_level == CW'(0));
  assign push  = in_valid && in_ready;

  // Storage array carries no reset; validity is tracked by fill_level.
  always_ff @(posedge clk30) begin
    if (push) begin
      mem[wr_ptr] <= {in_sol, in_data};
    end
  end

  always_comb begin
    fill_nxt = fill_level;
    case ({push, pop})
      2'b10:   fill_nxt = fill_level + CW'(1);
      2'b01:   fill_nxt = fill_level - CW'(1);
      default: fill_nxt = fill_level;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      in_ready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fill_level <= fill_nxt;
      in_ready   <= (fill_nxt != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Line sequencing: line_start overrides everything, including a coincident strobe.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pop          = 1'b0;
    emit         = 1'b0;
    emit_data    = '0;
    set_underrun = 1'b0;
    if (line_start) begin
      state_nxt = ACTIVE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        ACTIVE: begin
          if (line_pixels == CNTW'(0)) begin
            state_nxt = ALIGN;
          end else if (newpixel) begin
            emit    = 1'b1;
            cnt_nxt = cnt + CNTW'(1);
            if (!empty && (!head.sol || cnt == CNTW'(0))) begin
              pop       = 1'b1;
              emit_data = head.data;
            end else if (empty) begin
              set_underrun = 1'b1;
            end
            if (cnt_nxt == line_pixels) begin
              state_nxt = ALIGN;
            end
          end
        end
        ALIGN: begin
          // Drop the tail of an over-long decoder line up to the next line marker.
          if (!empty && !head.sol) begin
            pop = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_active <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      out_valid  <= emit;
      if (emit) begin
        out_data <= emit_data;
      end
      out_active <= (state == ACTIVE);
      if (set_underrun) begin
        underrun <= 1'b1;
      end else if (clear_status) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fmv_pixel_output.sv
// Scoreboard bench for fmv_pixel_output: expected pixels are queued per strobe
// and matched (data and one-cycle latency) when out_valid pulses.
module tb_fmv_pixel_output;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WIDTH = 24;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk30 = 1'b0;
  logic             reset_n = 1'b0;
  logic             line_start = 1'b0;
  logic             newpixel = 1'b0;
  logic [9:0]       line_pixels = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sol = 1'b0;
  logic             clear_status = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_active;
  logic             underrun;
  logic [CW-1:0]    fill_level;

  typedef struct {
    logic [WIDTH-1:0] data;
    int unsigned      cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  fmv_pixel_output #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk30        (clk30),
    .reset_n      (reset_n),
    .line_start   (line_start),
    .newpixel     (newpixel),
    .line_pixels  (line_pixels),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sol       (in_sol),
    .clear_status (clear_status),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_active   (out_active),
    .underrun     (underrun),
    .fill_level   (fill_level)
  );

  always #5 clk30 = ~clk30;
  always @(posedge clk30) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk30);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_px(input logic sol, input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_sol   = sol;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_sol   = 1'b0;
  endtask

  task automatic strobe(input logic [WIDTH-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
    newpixel = 1'b1;
    tick();
    newpixel = 1'b0;
  endtask

  task automatic stray_strobe();
    newpixel = 1'b1;
    tick();
    newpixel = 1'b0;
  endtask

  task automatic start_line(input logic [9:0] n);
    line_pixels = n;
    line_start  = 1'b1;
    tick();
    line_start  = 1'b0;
  endtask

  // Output monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk30) begin
    exp_t e;
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    idle(3);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_active", 32'(out_active), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    check("rst_fill", 32'(fill_level), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    reset_n = 1'b1;
    idle(2);

    // Basic line: four pixels, strobes spaced two cycles apart
    push_px(1'b1, 24'h000001);
    push_px(1'b0, 24'h000002);
    push_px(1'b0, 24'h000003);
    push_px(1'b0, 24'h000004);
    check("t1_fill4", 32'(fill_level), 32'(4));
    start_line(10'd4);
    strobe(24'h000001);
    check("t1_active", 32'(out_active), 32'(1));
    tick();
    strobe(24'h000002); tick();
    strobe(24'h000003); tick();
    strobe(24'h000004); tick();
    idle(3);
    stray_strobe();
    idle(2);
    check("t1_inactive", 32'(out_active), 32'(0));
    check("t1_underrun", 32'(underrun), 32'(0));
    check("t1_fill0", 32'(fill_level), 32'(0));
    check("t1_drain", 32'(exp_q.size()), 32'(0));

    // Underrun: two pixels for a four-pixel window
    push_px(1'b1, 24'h000001);
    push_px(1'b0, 24'h000002);
    start_line(10'd4);
    strobe(24'h000001);
    strobe(24'h000002);
    check("t2_no_underrun_yet", 32'(underrun), 32'(0));
    strobe(24'h000000);
    check("t2_underrun_set", 32'(underrun), 32'(1));
    strobe(24'h000000);
    idle(3);
    check("t2_underrun_sticky", 32'(underrun), 32'(1));
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("t2_underrun_clear", 32'(underrun), 32'(0));
    check("t2_drain", 32'(exp_q.size()), 32'(0));

    // Short decoder line: next line marker stays at head
    push_px(1'b1, 24'h0000A1);
    push_px(1'b0, 24'h0000A2);
    push_px(1'b1, 24'h0000B1);
    start_line(10'd3);
    strobe(24'h0000A1);
    strobe(24'h0000A2);
    strobe(24'h000000);
    idle(4);
    check("t3_underrun", 32'(underrun), 32'(0));
    check("t3_fill1", 32'(fill_level), 32'(1));
    check("t3_inactive", 32'(out_active), 32'(0));
    start_line(10'd1);
    strobe(24'h0000B1);
    idle(3);
    check("t3_fill0", 32'(fill_level), 32'(0));
    check("t3_drain", 32'(exp_q.size()), 32'(0));

    // Long decoder line: back-to-back strobes, then tail discard
    for (int i = 1; i <= 6; i++) push_px(i == 1, 24'(32'hA0 + i));
    push_px(1'b1, 24'h0000B1);
    check("t4_fill7", 32'(fill_level), 32'(7));
    start_line(10'd4);
    for (int i = 1; i <= 4; i++) strobe(24'(32'hA0 + i));
    check("t4_fill_after_line", 32'(fill_level), 32'(3));
    tick();
    check("t4_discard1", 32'(fill_level), 32'(2));
    tick();
    check("t4_discard2", 32'(fill_level), 32'(1));
    idle(3);
    check("t4_b1_kept", 32'(fill_level), 32'(1));
    start_line(10'd1);
    strobe(24'h0000B1);
    idle(3);
    check("t4_drain", 32'(exp_q.size()), 32'(0));

    // Full FIFO: blocked push alongside a pop
    for (int i = 0; i < int'(DEPTH); i++) push_px(i == 0, 24'(32'h100 + i));
    check("t5_fill_full", 32'(fill_level), 32'(DEPTH));
    check("t5_not_ready", 32'(in_ready), 32'(0));
    start_line(10'd2);
    in_valid = 1'b1;
    in_data  = 24'h00DEAD;
    strobe(24'h000100);
    in_valid = 1'b0;
    check("t5_fill_63", 32'(fill_level), 32'(DEPTH - 1));
    check("t5_ready_again", 32'(in_ready), 32'(1));
    strobe(24'h000101);
    idle(DEPTH + 8);
    check("t5_fill_discarded", 32'(fill_level), 32'(0));
    check("t5_drain", 32'(exp_q.size()), 32'(0));

    // Async reset in the middle of an active line
    start_line(10'd4);
    strobe(24'h000000);
    push_px(1'b0, 24'h000077);
    push_px(1'b0, 24'h000088);
    strobe(24'h000077);
    check("t6_pre_underrun", 32'(underrun), 32'(1));
    check("t6_pre_active", 32'(out_active), 32'(1));
    #6;
    reset_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'(0));
    check("t6_rst_out_data", 32'(out_data), 32'(0));
    check("t6_rst_out_active", 32'(out_active), 32'(0));
    check("t6_rst_underrun", 32'(underrun), 32'(0));
    check("t6_rst_fill", 32'(fill_level), 32'(0));
    check("t6_rst_in_ready", 32'(in_ready), 32'(1));
    idle(2);
    reset_n = 1'b1;
    idle(2);
    check("t6_drain", 32'(exp_q.size()), 32'(0));

    // line_start coincident with newpixel restarts the count, emits nothing
    push_px(1'b1, 24'h000031);
    push_px(1'b0, 24'h000032);
    push_px(1'b0, 24'h000033);
    start_line(10'd2);
    strobe(24'h000031);
    line_start = 1'b1;
    newpixel   = 1'b1;
    tick();
    line_start = 1'b0;
    newpixel   = 1'b0;
    check("t7_no_emit", 32'(out_valid), 32'(0));
    check("t7_fill2", 32'(fill_level), 32'(2));
    strobe(24'h000032);
    strobe(24'h000033);
    idle(3);
    stray_strobe();
    idle(2);
    check("t7_inactive", 32'(out_active), 32'(0));
    check("t7_fill0", 32'(fill_level), 32'(0));
    check("t7_drain", 32'(exp_q.size()), 32'(0));

    // Zero-length line: no emission, line marker left in place
    push_px(1'b1, 24'h000044);
    start_line(10'd0);
    stray_strobe();
    idle(3);
    check("t8_fill1", 32'(fill_level), 32'(1));
    check("t8_underrun", 32'(underrun), 32'(0));
    start_line(10'd1);
    strobe(24'h000044);
    idle(3);
    check("t8_fill0", 32'(fill_level), 32'(0));
    check("final_drain", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fmv_pixel_output.md
# fmv_pixel_output

Buffers decoded FMV pixels from the MPEG video decoder and releases them one per `newpixel` strobe from the sample rate converter, producing the FMV pixel stream for the video mixer. Holds a small FIFO tagged with start-of-line markers, limits each scanline to a programmed pixel count and realigns to the decoder's line boundaries. Substitutes black on underrun and flags it.

## Interface
- `DEPTH`, 64, FIFO entries; power of two, ≥4
- `WIDTH`, 24, pixel width (RGB888)

- `clk30`  in  1  30 MHz system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `line_start`  in  1  one-cycle pulse: FMV active window of a scanline begins
- `newpixel`  in  1  one-cycle strobe: emit next pixel (from sample rate converter)
- `line_pixels`  in  10  pixels to emit per line (e.g. 352 VCD, 384 base)
- `in_valid`  in  1  decoder pixel valid
- `in_ready`  out  1  FIFO can accept; `= !full`
- `in_data`  in  WIDTH  decoder pixel
- `in_sol`  in  1  marks first pixel of a decoded line
- `clear_status`  in  1  clears `underrun`
- `out_valid`  out  1  `out_data` is a new pixel this cycle
- `out_data`  out  WIDTH  output pixel
- `out_active`  out  1  high while the line window is open (state ACTIVE)
- `underrun`  out  1  sticky: a pixel was due with an empty FIFO
- `fill_level`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO entries are `{in_sol, in_data}`. Push when `in_valid && in_ready`. Pop only as described below. A push and a pop in the same cycle are both allowed; `fill_level` is unchanged.
- `in_ready` depends only on `full`. A pop in the same cycle does not free a slot for a push.
- The pixel counter `cnt` is 10 bits. States:
  - IDLE: `out_active=0`. No pops. `line_start` → ACTIVE, `cnt=0`.
  - ACTIVE: `out_active=1`. On `newpixel`:
    - FIFO non-empty and (head `sol=0` or `cnt==0`): pop and emit head data.
    - FIFO empty: emit 0 (black), set `underrun`.
    - Head `sol=1` and `cnt>0` (decoder line shorter than window): emit 0 without popping; `underrun` not set.
    - Each `newpixel` increments `cnt`. When the incremented `cnt==line_pixels` → ALIGN.
    - `line_pixels==0`: ACTIVE → ALIGN on the cycle after entry, with no emission.
  - ALIGN: `out_active=0`. Each cycle, pop and discard the head if the FIFO is non-empty and head `sol=0`. When head `sol=1` or the FIFO is empty → IDLE.
- `line_start` in any state forces ACTIVE, `cnt=0`. This takes priority over all other transitions and over a simultaneous `newpixel`; that strobe is ignored.
- `newpixel` outside ACTIVE is ignored: no pop, `out_valid=0`.
- `underrun`: set as above. `clear_status` clears it. A set in the same cycle wins over clear.

## Timing
- Reset (async assert, sync release) sets:
  - state=IDLE, FIFO empty, `cnt=0`
  - `out_valid=0`, `out_data=0`, `out_active=0`, `underrun=0`
  - `fill_level=0`, `in_ready=1`
- Latency `newpixel` → `out_valid`/`out_data`: 1 cycle (registered). `out_valid` is a one-cycle pulse. `out_data` holds its value between pulses.
- `fill_level` and `in_ready` are registered and reflect pushes/pops of the previous edge.
- FIFO read pointer wraps modulo DEPTH. Full is flagged at `fill_level==DEPTH`.
- Sustained rate: one emission per `newpixel`; back-to-back strobes (30 MHz base case) are supported.
- ALIGN discards at up to 1 entry/cycle.
- `out_active` is registered and changes on the edge after the state change.

## Test plan
- Push 4 pixels (first with sol) `0x000001..0x000004`, `line_pixels=4`, `line_start`, then 4 `newpixel` strobes spaced 2 cycles apart → 4 `out_valid` pulses, data 1..4, each 1 cycle after its strobe. Then state IDLE, `underrun=0`, `fill_level=0`.
- Underrun: FIFO holds 2 pixels, `line_pixels=4`, 4 strobes → data 1, 2, 0, 0; `underrun=1` after the 3rd strobe. `clear_status` → 0.
- Short decoder line: FIFO holds `A1,A2,B1(sol)`, `line_pixels=3` → outputs `A1,A2,0`; `underrun=0`; `B1` remains head; state IDLE.
- Long decoder line: FIFO holds `A1..A6,B1(sol)`, `line_pixels=4` → outputs `A1..A4`. ALIGN discards `A5,A6` in 2 cycles, leaving `B1` at head with `fill_level=1`.
- Full: push 64 with no pops → `in_ready=0` and `fill_level=64`. Simultaneous `in_valid` and a pop → no push; `fill_level=63`, then `in_ready=1`.
- Async `reset_n` low mid-ACTIVE, with no clock edge → all outputs immediately at reset values. `line_start` coincident with `newpixel` → no emission, `cnt=0`.
